bram_selftest: RTL and testbench
================================

# bram_selftest

Parametrised built-in self-test controller for a true dual-port block RAM. On `start` it drives both RAM ports concurrently through a four-phase pattern test: write a true pattern, read/compare, write the inverted pattern, read/compare. It reports pass/fail, the first failing address and a saturating error count. It sits between the system controller and the dual-port BRAM and replaces fixed hand-sequenced RAM bring-up.

## Interface
- `DATA_WIDTH`, 16: RAM word width.
- `ADDR_WIDTH`, 10: RAM address width. Depth D = 2**ADDR_WIDTH; half-depth H = D/2. ADDR_WIDTH must be ≥ 2.
- `BG`, 16'hA5A5: background word. It is truncated or zero-extended to DATA_WIDTH.

Ports:
- `clk` in 1: clock, all logic on posedge.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: begin test; sampled only in IDLE.
- `abort` in 1: synchronous cancel.
- `q_a`, `q_b` in DATA_WIDTH: RAM read data, valid one cycle after the address is presented.
- `data_a`, `data_b` out DATA_WIDTH: write data.
- `addr_a`, `addr_b` out ADDR_WIDTH: addresses.
- `we_a`, `we_b` out 1: write enables.
- `busy` out 1: high outside IDLE/DONE.
- `done` out 1: one-cycle pulse at test completion.
- `pass` out 1: result, held until the next accepted start.
- `err_addr` out ADDR_WIDTH: first failing address.
- `err_count` out 16: mismatching words, saturates at 16'hFFFF.

## Operation
- States: IDLE, WR_P, RD_P, WR_N, RD_N, FLUSH, DONE.
- Transitions:
  - IDLE→WR_P when `start`=1.
  - Each of WR_P→RD_P→WR_N→RD_N advances after the index counter reaches H-1.
  - RD_N→FLUSH, FLUSH→DONE, DONE→IDLE unconditionally.
- Index counter i runs 0..H-1 and clears on every phase change.
- Port A covers address i; port B covers address i+H. Port A covers the lower half and port B the upper half.
- Pattern: P(a) = BG ^ a, with a zero-extended to DATA_WIDTH. N(a) = ~P(a).
- WR_P and WR_N: `we_a`/`we_b` are 1 and the data equals P or N of the respective address.
- RD_P and RD_N: `we_*` are 0 and `data_*` are 0.
- Compare pipeline: the expected value and address for each port are registered with a valid bit. A compare fires one cycle after each read address. The last RD_P compare overlaps the first WR_N cycle; the last RD_N compare occurs in FLUSH.
- Mismatch handling:
  - `err_count` increments by 1 per failing port per cycle, so it can add 2 in one cycle.
  - The first mismatch latches `err_addr`. If both ports fail in the same cycle, port A's address wins.
  - `pass` is cleared.
- Accepted start sets `pass`=1 and clears `err_addr` and `err_count`.
- `start` while busy is ignored.
- `abort` outside IDLE: next state is IDLE. `we_*` go to 0, the compare pipeline is flushed, `pass`=0 and no `done` pulse is issued. `abort` in IDLE has no effect. If `abort` and `start` arrive in the same cycle in IDLE, `start` wins.
- `reset` at any point, including mid-write: every register returns to its reset value immediately. The RAM contents are then undefined.

## Timing
- All outputs are registered.
- Reset values: state IDLE; `data_*`=0, `addr_*`=0, `we_*`=0, `busy`=0, `done`=0, `pass`=0, `err_addr`=0, `err_count`=0.
- Start accepted at edge k:
  - The first write is presented in cycle k+1.
  - Each phase lasts H cycles.
  - FLUSH is at cycle 4H+1.
  - `done`=1 at cycle 4H+2. With ADDR_WIDTH=10 that is cycle 2050.
- Read latency assumed from the RAM is exactly 1 cycle, with no write-through requirement.

## Structure
- Shared package/header `bram_pkg`: state encodings, the 16-bit error-count width and its saturation constant.
- One sub-module: `bist_pattern_gen`. It is purely combinational, maps (address, phase polarity, BG) to a data word, and is instantiated once per port for both write data and expected data.
- The top level holds the FSM, index counter, compare pipeline and result registers.

## Test plan
Bench uses ADDR_WIDTH=4, DATA_WIDTH=16, BG=16'hA5A5 (so H=8), with a behavioural dual-port RAM that has 1-cycle read latency and fault injection.

- **Fault-free:** start pulse → `done` at cycle 34, `pass`=1, `err_count`=0, `busy` high cycles 1–33.
- **Stuck-at-0, port A:** bit0 of address 5 stuck at 0 → P=A5A0 passes, N=5A5F fails. Expect `pass`=0, `err_addr`=5, `err_count`=1.
- **Stuck-at-1, port B:** bit3 of address 12 stuck at 1 → N=5A56 fails. Expect `err_addr`=12, `err_count`=1.
- **Simultaneous faults:** every bit of addresses 3 and 11 inverted on read → both fail in the same cycle in RD_P and RD_N. Expect `err_addr`=3, `err_count`=4.
- **Abort:** abort during WR_N → IDLE next cycle, `we_*`=0, no `done`, `pass`=0. A second start then yields a clean pass at cycle 34.
- **Reset and busy-start:** reset asserted mid-RD_P → all outputs at reset values asynchronously. Start re-pulsed while busy → ignored, `done` timing unchanged.

Source files
------------

// File: rtl/bram_pkg.sv
// Shared definitions for the dual-port BRAM self-test controller:
// FSM state encoding and error-count width/saturation value.
package bram_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR_P  = 3'd1,
        S_RD_P  = 3'd2,
        S_WR_N  = 3'd3,
        S_RD_N  = 3'd4,
        S_FLUSH = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam int             ERR_W   = 16;
    localparam logic [ERR_W-1:0] ERR_SAT = 16'hFFFF;

    function automatic logic is_neg_phase(input state_t s);
        return (s == S_WR_N) || (s == S_RD_N);
    endfunction

endpackage

// File: rtl/bram_selftest_pattern_gen.sv
// Combinational pattern source: P(a) = bg ^ a (zero-extended), N(a) = ~P(a).
module bist_pattern_gen
    import bram_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  inv,
    input  logic [DATA_WIDTH-1:0] bg,
    output logic [DATA_WIDTH-1:0] word
);

    logic [DATA_WIDTH-1:0] pat;

    assign pat  = bg ^ DATA_WIDTH'(addr);
    assign word = inv ? ~pat : pat;

endmodule

// File: rtl/bram_selftest.sv
// Dual-port BRAM BIST: write P, read/compare, write N, read/compare, with
// port A sweeping the lower half and port B the upper half concurrently.
//
// state   | meaning
// IDLE    | waiting for start; results held
// WR_P    | both ports write true pattern
// RD_P    | both ports read, compare against true pattern
// WR_N    | both ports write inverted pattern
// RD_N    | both ports read, compare against inverted pattern
// FLUSH   | last RD_N compare lands here
// DONE    | one-cycle done pulse
module bram_selftest
    import bram_pkg::*;
#(
    parameter int          DATA_WIDTH = 16,
    parameter int          ADDR_WIDTH = 10,
    parameter logic [15:0] BG         = 16'hA5A5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] q_a,
    input  logic [DATA_WIDTH-1:0] q_b,
    output logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] data_b,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic                  we_a,
    output logic                  we_b,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic [ERR_W-1:0]      err_count
);

    localparam int                    IW       = ADDR_WIDTH - 1;
    localparam logic [IW-1:0]         IDX_LAST = '1;
    localparam logic [DATA_WIDTH-1:0] BG_W     = DATA_WIDTH'(BG);

    state_t                state, nxt_state;
    logic [IW-1:0]         idx, nxt_idx;
    logic                  nxt_wr, nxt_rd, nxt_inv, abort_hit;
    logic [ADDR_WIDTH-1:0] nxt_addr_a, nxt_addr_b;
    logic [DATA_WIDTH-1:0] pat_a, pat_b;

    logic                  vld1, vld2;
    logic [DATA_WIDTH-1:0] exp1_a, exp1_b, exp2_a, exp2_b;
    logic [ADDR_WIDTH-1:0] addr2_a, addr2_b;
    logic                  fail_a, fail_b;
    logic [ERR_W:0]        err_sum;

    assign abort_hit = abort && (state != S_IDLE);

    always_comb begin
        nxt_state = state;
        nxt_idx   = '0;
        case (state)
            S_IDLE:  if (start) nxt_state = S_WR_P;
            S_WR_P, S_RD_P, S_WR_N, S_RD_N: begin
                if (idx == IDX_LAST) begin
                    case (state)
                        S_WR_P:  nxt_state = S_RD_P;
                        S_RD_P:  nxt_state = S_WR_N;
                        S_WR_N:  nxt_state = S_RD_N;
                        default: nxt_state = S_FLUSH;
                    endcase
                end else begin
                    nxt_idx = idx + 1'b1;
                end
            end
            S_FLUSH: nxt_state = S_DONE;
            default: nxt_state = S_IDLE;
        endcase
        if (abort_hit) begin
            nxt_state = S_IDLE;
            nxt_idx   = '0;
        end
    end

    assign nxt_wr     = (nxt_state == S_WR_P) || (nxt_state == S_WR_N);
    assign nxt_rd     = (nxt_state == S_RD_P) || (nxt_state == S_RD_N);
    assign nxt_inv    = is_neg_phase(nxt_state);
    assign nxt_addr_a = {1'b0, nxt_idx};
    assign nxt_addr_b = {1'b1, nxt_idx};

    // One generator per port supplies both write data and expected read data.
    bist_pattern_gen #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_pat_a (
        .addr (nxt_addr_a),
        .inv  (nxt_inv),
        .bg   (BG_W),
        .word (pat_a)
    );

    bist_pattern_gen #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_pat_b (
        .addr (nxt_addr_b),
        .inv  (nxt_inv),
        .bg   (BG_W),
        .word (pat_b)
    );

    // Stage 2 lines up with RAM read data one cycle after the address.
    assign fail_a  = vld2 && (q_a != exp2_a);
    assign fail_b  = vld2 && (q_b != exp2_b);
    assign err_sum = {1'b0, err_count} + (ERR_W+1)'(fail_a) + (ERR_W+1)'(fail_b);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            data_a    <= '0;
            data_b    <= '0;
            addr_a    <= '0;
            addr_b    <= '0;
            we_a      <= 1'b0;
            we_b      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_addr  <= '0;
            err_count <= '0;
            vld1      <= 1'b0;
            vld2      <= 1'b0;
            exp1_a    <= '0;
            exp1_b    <= '0;
            exp2_a    <= '0;
            exp2_b    <= '0;
            addr2_a   <= '0;
            addr2_b   <= '0;
        end else begin
            state   <= nxt_state;
            idx     <= nxt_idx;
            we_a    <= nxt_wr;
            we_b    <= nxt_wr;
            data_a  <= nxt_wr ? pat_a : '0;
            data_b  <= nxt_wr ? pat_b : '0;
            addr_a  <= (nxt_wr || nxt_rd) ? nxt_addr_a : '0;
            addr_b  <= (nxt_wr || nxt_rd) ? nxt_addr_b : '0;
            busy    <= (nxt_state != S_IDLE) && (nxt_state != S_DONE);
            done    <= (nxt_state == S_DONE);

            vld1    <= nxt_rd;
            exp1_a  <= pat_a;
            exp1_b  <= pat_b;
            vld2    <= vld1;
            exp2_a  <= exp1_a;
            exp2_b  <= exp1_b;
            addr2_a <= addr_a;
            addr2_b <= addr_b;

            if (abort_hit) begin
                vld1 <= 1'b0;
                vld2 <= 1'b0;
                pass <= 1'b0;
            end else if ((state == S_IDLE) && start) begin
                pass      <= 1'b1;
                err_addr  <= '0;
                err_count <= '0;
            end else if (fail_a || fail_b) begin
                pass      <= 1'b0;
                err_count <= err_sum[ERR_W] ? ERR_SAT : err_sum[ERR_W-1:0];
                // A saturating count never returns to zero, so zero means no mismatch yet.
                if (err_count == '0)
                    err_addr <= fail_a ? addr2_a : addr2_b;
            end
        end
    end

endmodule

// File: tb/tb_bram_selftest.sv
// Self-checking bench for bram_selftest with a 1-cycle-latency dual-port RAM
// model carrying per-address stuck-at and inversion faults on read.
module tb_bram_selftest;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int D  = 16;
    localparam int H  = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] q_a, q_b, data_a, data_b;
    logic [AW-1:0] addr_a, addr_b, err_addr;
    logic          we_a, we_b, busy, done, pass;
    logic [15:0]   err_count;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mem [D];
    logic [DW-1:0] s0  [D];
    logic [DW-1:0] s1  [D];
    logic [DW-1:0] fx  [D];

    always #5 clk = ~clk;

    bram_selftest #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BG(16'hA5A5)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .q_a       (q_a),
        .q_b       (q_b),
        .data_a    (data_a),
        .data_b    (data_b),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .we_a      (we_a),
        .we_b      (we_b),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_addr  (err_addr),
        .err_count (err_count)
    );

    function automatic logic [DW-1:0] faulty(input int a, input logic [DW-1:0] w);
        return ((w & ~s0[a]) | s1[a]) ^ fx[a];
    endfunction

    function automatic logic [DW-1:0] pat(input int a, input bit neg);
        logic [DW-1:0] p;
        p = 16'hA5A5 ^ 16'(a);
        return neg ? ~p : p;
    endfunction

    always @(posedge clk) begin
        if (we_a) mem[addr_a] <= data_a;
        if (we_b) mem[addr_b] <= data_b;
        q_a <= faulty(int'(addr_a), mem[addr_a]);
        q_b <= faulty(int'(addr_b), mem[addr_b]);
    end

    task automatic clear_faults();
        for (int a = 0; a < D; a++) begin
            s0[a] = '0;
            s1[a] = '0;
            fx[a] = '0;
        end
    endtask

    // Expected outcome from the test rules: each address holds P then N;
    // compares run in time order, lower-half port first within a cycle.
    task automatic model_expect(output int cnt, output int first);
        logic [DW-1:0] w;
        int a;
        cnt   = 0;
        first = 0;
        for (int ph = 0; ph < 2; ph++)
            for (int i = 0; i < H; i++)
                for (int port = 0; port < 2; port++) begin
                    a = i + port * H;
                    w = pat(a, ph == 1);
                    if (faulty(a, w) !== w) begin
                        if (cnt == 0) first = a;
                        cnt++;
                    end
                end
    endtask

    // Runs one test from a start pulse; cycle 1 is the cycle after the start edge.
    task automatic run_bist(input int abort_cyc, input int restart_cyc,
                            output int done_cyc, output int done_count,
                            output int busy_bad, output int proto_bad,
                            output logic snap_we, output logic snap_busy,
                            output logic snap_pass);
        bit aborted;
        int ph, i;
        bit wr, neg;
        logic [DW-1:0] exp_da, exp_db;
        aborted = 0;
        done_cyc = -1; done_count = 0; busy_bad = 0; proto_bad = 0;
        snap_we = 1'b0; snap_busy = 1'b0; snap_pass = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (!aborted) begin
                if (busy !== (cyc <= 4 * H + 1)) busy_bad++;
                if (cyc <= 4 * H) begin
                    ph  = (cyc - 1) / H;
                    i   = (cyc - 1) % H;
                    wr  = (ph % 2) == 0;
                    neg = ph >= 2;
                    exp_da = wr ? pat(i, neg) : '0;
                    exp_db = wr ? pat(i + H, neg) : '0;
                    if (we_a !== wr || we_b !== wr || addr_a !== AW'(i) ||
                        addr_b !== AW'(i + H) || data_a !== exp_da || data_b !== exp_db)
                        proto_bad++;
                end
            end
            if (cyc == abort_cyc + 1) begin
                snap_we   = we_a | we_b;
                snap_busy = busy;
                snap_pass = pass;
            end
            if (done === 1'b1) begin
                done_count++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (cyc == abort_cyc)   abort = 1'b1;
            if (cyc == restart_cyc) start = 1'b1;
            @(posedge clk);
            #1;
            abort = 1'b0;
            start = 1'b0;
            if (cyc == abort_cyc) aborted = 1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done: got %b expected 0", done); end
        total++; if (pass !== 1'b0)      begin bad++; $display("FAIL reset_pass: got %b expected 0", pass); end
        total++; if ({we_a, we_b} !== 2'b00) begin bad++; $display("FAIL reset_we: got %b expected 00", {we_a, we_b}); end
        total++; if (err_count !== 16'd0 || err_addr !== 4'd0)
            begin bad++; $display("FAIL reset_err: got cnt=%0d addr=%0d expected 0/0", err_count, err_addr); end
        total++; if (data_a !== 16'd0 || data_b !== 16'd0 || addr_a !== 4'd0 || addr_b !== 4'd0)
            begin bad++; $display("FAIL reset_bus: got da=%h db=%h aa=%0d ab=%0d expected zeros", data_a, data_b, addr_a, addr_b); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0)
            begin bad++; $display("FAIL idle_after_reset: got busy=%b done=%b expected 0/0", busy, done); end
    endtask

    task automatic check_result(input string name, input int done_cyc, input int done_count,
                                input logic exp_pass, input int exp_addr, input int exp_cnt);
        total++; if (done_cyc != 34 || done_count != 1)
            begin bad++; $display("FAIL %s_done: got cycle=%0d pulses=%0d expected 34/1", name, done_cyc, done_count); end
        total++; if (pass !== exp_pass)
            begin bad++; $display("FAIL %s_pass: got %b expected %b", name, pass, exp_pass); end
        total++; if (err_addr !== AW'(exp_addr))
            begin bad++; $display("FAIL %s_err_addr: got %0d expected %0d", name, err_addr, exp_addr); end
        total++; if (err_count !== 16'(exp_cnt))
            begin bad++; $display("FAIL %s_err_count: got %0d expected %0d", name, err_count, exp_cnt); end
    endtask

    task automatic test_fault_free();
        int dc, dn, bb, pb;
        logic sw, sb, sp;
        clear_faults();
        run_bist(-10, -10, dc, dn, bb, pb, sw, sb, sp);
        total++; if (bb != 0) begin bad++; $display("FAIL ff_busy_window: got %0d bad cycles expected 0", bb); end
        total++; if (pb != 0) begin bad++; $display("FAIL ff_port_schedule: got %0d bad cycles expected 0", pb); end
        check_result("ff", dc, dn, 1'b1, 0, 0);
    endtask

    task automatic test_stuck_a();
        int dc, dn, bb, pb;
        logic sw, sb, sp;
        clear_faults();
        s0[5] = 16'h0001;
        run_bist(-10, -10, dc, dn, bb, pb, sw, sb, sp);
        check_result("sa0_a", dc, dn, 1'b0, 5, 1);
    endtask

    task automatic test_stuck_b();
        int dc, dn, bb, pb;
        logic sw, sb, sp;
        clear_faults();
        s1[12] = 16'h0008;
        run_bist(-10, -10, dc, dn, bb, pb, sw, sb, sp);
        check_result("sa1_b", dc, dn, 1'b0, 12, 1);
    endtask

    task automatic test_simultaneous();
        int dc, dn, bb, pb;
        logic sw, sb, sp;
        clear_faults();
        fx[3]  = 16'hFFFF;
        fx[11] = 16'hFFFF;
        run_bist(-10, -10, dc, dn, bb, pb, sw, sb, sp);
        check_result("simul", dc, dn, 1'b0, 3, 4);
    endtask

    task automatic test_random();
        int dc, dn, bb, pb, cnt, first, a, kind;
        logic sw, sb, sp;
        for (int it = 0; it < 6; it++) begin
            clear_faults();
            for (int f = 0; f < int'($urandom_range(0, 3)); f++) begin
                a    = int'($urandom_range(0, D - 1));
                kind = int'($urandom_range(0, 2));
                case (kind)
                    0:       s0[a] = s0[a] | 16'(1 << $urandom_range(0, DW - 1));
                    1:       s1[a] = s1[a] | 16'(1 << $urandom_range(0, DW - 1));
                    default: fx[a] = 16'($urandom);
                endcase
            end
            model_expect(cnt, first);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_bist(-10, -10, dc, dn, bb, pb, sw, sb, sp);
            check_result("rand", dc, dn, cnt == 0, first, cnt);
        end
    endtask

    task automatic test_abort();
        int dc, dn, bb, pb;
        logic sw, sb, sp;
        clear_faults();
        run_bist(19, -10, dc, dn, bb, pb, sw, sb, sp);
        total++; if (sw !== 1'b0) begin bad++; $display("FAIL abort_we: got %b expected 0", sw); end
        total++; if (sb !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b expected 0", sb); end
        total++; if (sp !== 1'b0) begin bad++; $display("FAIL abort_pass: got %b expected 0", sp); end
        total++; if (dn != 0)     begin bad++; $display("FAIL abort_no_done: got %0d pulses expected 0", dn); end
        run_bist(-10, -10, dc, dn, bb, pb, sw, sb, sp);
        check_result("after_abort", dc, dn, 1'b1, 0, 0);
    endtask

    task automatic test_reset_mid();
        int dc, dn, bb, pb;
        logic sw, sb, sp;
        clear_faults();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (11) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0)
            begin bad++; $display("FAIL midreset_flags: got busy=%b done=%b pass=%b expected 000", busy, done, pass); end
        total++; if (addr_a !== 4'd0 || addr_b !== 4'd0 || we_a !== 1'b0 || we_b !== 1'b0)
            begin bad++; $display("FAIL midreset_bus: got aa=%0d ab=%0d we=%b%b expected zeros", addr_a, addr_b, we_a, we_b); end
        @(negedge clk);
        reset = 1'b1;
        run_bist(-10, -10, dc, dn, bb, pb, sw, sb, sp);
        check_result("after_midreset", dc, dn, 1'b1, 0, 0);
    endtask

    task automatic test_busy_start();
        int dc, dn, bb, pb;
        logic sw, sb, sp;
        clear_faults();
        run_bist(-10, 10, dc, dn, bb, pb, sw, sb, sp);
        total++; if (bb != 0) begin bad++; $display("FAIL busy_start_window: got %0d bad cycles expected 0", bb); end
        check_result("busy_start", dc, dn, 1'b1, 0, 0);
    endtask

    initial begin
        for (int a = 0; a < D; a++) mem[a] = '0;
        clear_faults();
        #2 reset = 1'b0;
        test_reset();
        test_fault_free();
        test_stuck_a();
        test_stuck_b();
        test_simultaneous();
        test_random();
        test_abort();
        test_reset_mid();
        test_busy_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
